// File: rtl/async_fifo.sv
// -----------------------------------------------------------------------------
// async_fifo
//   Gray-pointer FIFO core with one writer and one reader on a single clock.
//   Sits between a producer and a consumer as storage plus flow control.
//
//   Optional feature macro: ASYNC_FIFO_PTR_SYNC_EN
//     Defined     : each side sees the opposite Gray pointer through a 2-flop
//                   synchroniser, which models dual-domain flag latency.
//                   The side that sets a flag does so at the same edge.
//                   The side that clears a flag is delayed by three edges.
//     Not defined : pointers are compared directly, so both flags track the
//                   operation at the same edge.
//
// Parameters
//   DEPTH     number of entries, must equal 2**PTRWIDTH
//   PTRWIDTH  address width; pointers carry one extra wrap bit
//   DWIDTH    data word width
//
// Ports
//   clk      in   single clock, rising edge
//   reset_L  in   asynchronous active-low reset
//   push     in   write request
//   wdata    in   write data, sampled with push
//   full     out  FIFO full, push ignored while high (registered)
//   pop      in   read request
//   rdata    out  read data, registered, valid the cycle after the pop edge
//   empty    out  FIFO empty, pop ignored while high (registered)
// -----------------------------------------------------------------------------
module async_fifo #(
   parameter int DEPTH    = 16,
   parameter int PTRWIDTH = 4,
   parameter int DWIDTH   = 8
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              push,
   input  logic [DWIDTH-1:0] wdata,
   output logic              full,
   input  logic              pop,
   output logic [DWIDTH-1:0] rdata,
   output logic              empty
);

   localparam int PW = PTRWIDTH + 1;

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Storage is deliberately not reset so it maps onto block RAM.
   logic [DWIDTH-1:0] mem [DEPTH];

   logic [PW-1:0]     wptr_reg;
   logic [PW-1:0]     rptr_reg;
   logic [PW-1:0]     wptr_next;
   logic [PW-1:0]     rptr_next;
   logic [PW-1:0]     wptr_gray_next;
   logic [PW-1:0]     rptr_gray_next;
   logic [PW-1:0]     wptr_gray_seen;   // write pointer as seen by the empty logic
   logic [PW-1:0]     rptr_gray_seen;   // read pointer as seen by the full logic
   logic              empty_reg;
   logic              full_reg;
   logic              empty_next;
   logic              full_next;
   logic [DWIDTH-1:0] rdata_reg;
   logic              wr_en;
   logic              rd_en;

   // Flags are registered, so accepting a request never depends combinationally
   // on the same-cycle request of the other side.
   assign wr_en = push & ~full_reg;
   assign rd_en = pop  & ~empty_reg;

   // Natural overflow wraps 2*DEPTH-1 back to 0.
   assign wptr_next      = wptr_reg + {{(PW-1){1'b0}}, wr_en};
   assign rptr_next      = rptr_reg + {{(PW-1){1'b0}}, rd_en};
   assign wptr_gray_next = bin2gray(wptr_next);
   assign rptr_gray_next = bin2gray(rptr_next);

`ifdef ASYNC_FIFO_PTR_SYNC_EN
   logic [PW-1:0] wptr_gray_reg;
   logic [PW-1:0] rptr_gray_reg;
   logic [PW-1:0] wsync1_reg;
   logic [PW-1:0] wsync2_reg;
   logic [PW-1:0] rsync1_reg;
   logic [PW-1:0] rsync2_reg;

   // Each side only ever looks at the other side's registered Gray pointer
   // after two flops, as it would across a real clock boundary.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wptr_gray_reg <= '0;
         rptr_gray_reg <= '0;
         wsync1_reg    <= '0;
         wsync2_reg    <= '0;
         rsync1_reg    <= '0;
         rsync2_reg    <= '0;
      end else begin
         wptr_gray_reg <= wptr_gray_next;
         rptr_gray_reg <= rptr_gray_next;
         wsync1_reg    <= wptr_gray_reg;
         wsync2_reg    <= wsync1_reg;
         rsync1_reg    <= rptr_gray_reg;
         rsync2_reg    <= rsync1_reg;
      end
   end

   assign wptr_gray_seen = wsync2_reg;
   assign rptr_gray_seen = rsync2_reg;
`else
   // Direct comparison: the opposite pointer is seen at its next-state value.
   assign wptr_gray_seen = wptr_gray_next;
   assign rptr_gray_seen = rptr_gray_next;
`endif

   // Own pointer is always taken at next-state, so the setting side reacts at
   // the same edge while the clearing side waits for the seen pointer.
   assign empty_next = (rptr_gray_next == wptr_gray_seen);
   // Full in Gray code: top two bits inverted, the rest equal.
   assign full_next  = (wptr_gray_next ==
                        {~rptr_gray_seen[PW-1:PW-2], rptr_gray_seen[PW-3:0]});

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wptr_reg[PTRWIDTH-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wptr_reg  <= '0;
         rptr_reg  <= '0;
         empty_reg <= 1'b1;
         full_reg  <= 1'b0;
         rdata_reg <= '0;
      end else begin
         wptr_reg  <= wptr_next;
         rptr_reg  <= rptr_next;
         empty_reg <= empty_next;
         full_reg  <= full_next;
         if (rd_en) begin
            rdata_reg <= mem[rptr_reg[PTRWIDTH-1:0]];
         end
      end
   end

   assign empty = empty_reg;
   assign full  = full_reg;
   assign rdata = rdata_reg;

endmodule

// File: tb/tb_async_fifo.sv
// -----------------------------------------------------------------------------
// tb_async_fifo
//   Self-checking bench for async_fifo. A reference model keeps the stored
//   words in a queue plus running totals of accepted writes and reads; flag
//   visibility delay is expressed as "the other side's total LAT edges ago".
//   Works for both builds of the ASYNC_FIFO_PTR_SYNC_EN macro.
// -----------------------------------------------------------------------------
module tb_async_fifo;

   localparam int DEPTH    = 16;
   localparam int PTRWIDTH = 4;
   localparam int DWIDTH   = 8;
`ifdef ASYNC_FIFO_PTR_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 0;
`endif

   logic              clk     = 1'b0;
   logic              reset_L = 1'b1;
   logic              push    = 1'b0;
   logic              pop     = 1'b0;
   logic [DWIDTH-1:0] wdata   = '0;
   logic              full;
   logic              empty;
   logic [DWIDTH-1:0] rdata;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [DWIDTH-1:0] model_q [$];
   int                wcnt;
   int                rcnt;
   int                whist [$];   // write total after each edge since reset
   int                rhist [$];   // read total after each edge since reset
   logic              exp_empty;
   logic              exp_full;
   logic [DWIDTH-1:0] exp_rdata;

   async_fifo #(
      .DEPTH   (DEPTH),
      .PTRWIDTH(PTRWIDTH),
      .DWIDTH  (DWIDTH)
   ) dut (
      .clk    (clk),
      .reset_L(reset_L),
      .push   (push),
      .wdata  (wdata),
      .full   (full),
      .pop    (pop),
      .rdata  (rdata),
      .empty  (empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Other side's total as it was LAT edges ago (0 before any edge since reset).
   function automatic int w_seen();
      int idx = whist.size() - 1 - LAT;
      return (idx < 0) ? 0 : whist[idx];
   endfunction

   function automatic int r_seen();
      int idx = rhist.size() - 1 - LAT;
      return (idx < 0) ? 0 : rhist[idx];
   endfunction

   task automatic model_reset();
      model_q.delete();
      whist.delete();
      rhist.delete();
      wcnt      = 0;
      rcnt      = 0;
      exp_empty = 1'b1;
      exp_full  = 1'b0;
      exp_rdata = '0;
   endtask

   // One clock edge with the given requests; updates the model and checks
   // every output 1 ns after the edge.
   task automatic step(input logic p, input logic o, input logic [DWIDTH-1:0] d);
      logic do_push;
      logic do_pop;
      push  = p;
      pop   = o;
      wdata = d;
      @(posedge clk);
      do_push = p && !exp_full;
      do_pop  = o && !exp_empty;
      if (do_pop) begin
         exp_rdata = model_q.pop_front();
         rcnt++;
      end
      if (do_push) begin
         model_q.push_back(d);
         wcnt++;
      end
      whist.push_back(wcnt);
      rhist.push_back(rcnt);
      exp_empty = (rcnt == w_seen());
      exp_full  = ((wcnt - r_seen()) == DEPTH);
      #1;
      push = 1'b0;
      pop  = 1'b0;
      $display("step push=%0d pop=%0d wdata=%02h -> empty=%0d full=%0d rdata=%02h occ=%0d",
               p, o, d, empty, full, rdata, model_q.size());
      check("empty", {31'd0, empty}, {31'd0, exp_empty});
      check("full",  {31'd0, full},  {31'd0, exp_full});
      check("rdata", {24'd0, rdata}, {24'd0, exp_rdata});
   endtask

   // Reset asserted between edges; outputs must respond without a clock.
   task automatic do_reset(input string tag);
      #2;
      reset_L = 1'b0;
      #1;
      model_reset();
      $display("reset %s -> empty=%0d full=%0d rdata=%02h", tag, empty, full, rdata);
      check({tag, "_empty"}, {31'd0, empty}, 32'd1);
      check({tag, "_full"},  {31'd0, full},  32'd0);
      check({tag, "_rdata"}, {24'd0, rdata}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset_L = 1'b1;
      step(1'b0, 1'b0, '0);
   endtask

   task automatic drain_and_settle();
      for (int i = 0; i < 4 * DEPTH && model_q.size() > 0; i++) step(1'b0, 1'b1, '0);
      for (int i = 0; i <= LAT; i++) step(1'b0, 1'b0, '0);
      check("drain_done", {31'd0, empty}, 32'd1);
   endtask

   initial begin
      model_reset();

      // Reset without any clock dependence
      do_reset("reset");

      // Fill with 0x00..0x0F, then a dropped push of 0xAA
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i));
      check("fill_full", {31'd0, full}, 32'd1);
      step(1'b1, 1'b0, 8'hAA);
      check("overflow_full", {31'd0, full}, 32'd1);

      // Drain in order, then one pop while empty
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b1, '0);
         check("drain_data", {24'd0, rdata}, i);
      end
      check("drain_empty", {31'd0, empty}, 32'd1);
      step(1'b0, 1'b1, '0);
      check("underflow_rdata", {24'd0, rdata}, 32'h0F);

      // Wrap: low occupancy traffic carries pointers past the index wrap
      step(1'b1, 1'b0, 8'($urandom));
      for (int i = 0; i < 80; i++) begin
         logic p;
         logic o;
         p = (model_q.size() < 3) && ($urandom_range(0, 2) != 0);
         o = (model_q.size() > 1) || ($urandom_range(0, 1) == 1);
         step(p, o, 8'($urandom));
         check("wrap_not_full", {31'd0, full}, 32'd0);
      end

      // Simultaneous push and pop at occupancy 5
      drain_and_settle();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
      for (int i = 0; i < LAT; i++) step(1'b0, 1'b0, '0);
      step(1'b1, 1'b1, 8'h55);
      check("simul_head", {24'd0, rdata}, 32'h10);
      check("simul_occ", model_q.size(), 32'd5);
      drain_and_settle();
      check("simul_tail", {24'd0, rdata}, 32'h55);

      // Push and pop together while empty: only the push happens
      step(1'b1, 1'b1, 8'h66);
      check("empty_pp_rdata", {24'd0, rdata}, 32'h55);
      check("empty_pp_flag", {31'd0, empty}, (LAT == 0) ? 32'd0 : 32'd1);
      for (int i = 0; i < LAT; i++) step(1'b0, 1'b0, '0);
      check("empty_pp_late", {31'd0, empty}, 32'd0);
      step(1'b0, 1'b1, '0);
      check("empty_pp_data", {24'd0, rdata}, 32'h66);

      // Flag clearing latency: empty after a push, full after a pop
      drain_and_settle();
      step(1'b1, 1'b0, 8'h77);
      check("empty_lat_0", {31'd0, empty}, (0 < LAT) ? 32'd1 : 32'd0);
      for (int j = 1; j <= 3; j++) begin
         step(1'b0, 1'b0, '0);
         check("empty_lat", {31'd0, empty}, (j < LAT) ? 32'd1 : 32'd0);
      end
      for (int i = 0; i < 2 * DEPTH && !exp_full; i++) step(1'b1, 1'b0, 8'($urandom));
      check("full_reached", {31'd0, full}, 32'd1);
      step(1'b0, 1'b1, '0);
      check("full_lat_0", {31'd0, full}, (0 < LAT) ? 32'd1 : 32'd0);
      for (int j = 1; j <= 3; j++) begin
         step(1'b0, 1'b0, '0);
         check("full_lat", {31'd0, full}, (j < LAT) ? 32'd1 : 32'd0);
      end

      // Reset mid-operation discards contents
      do_reset("midreset");
      check("midreset_after", {31'd0, empty}, 32'd1);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      end
      drain_and_settle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
